// File: rtl/conv2_pkg.sv
// conv2_pkg: shared constants, FSM encoding and result-tag type for the layer-2 conv scheduler.
package conv2_pkg;
    localparam int FILTER_SIZE = 5;
    localparam int OUT_CH      = 3;
    localparam int CW          = 4;
    localparam int CH_W        = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;

    typedef enum logic [1:0] {FILL, ISSUE, DRAIN} state_t;

    typedef struct packed {
        logic            valid;
        logic [CH_W-1:0] ch;
        logic [CW-1:0]   row;
        logic [CW-1:0]   col;
    } tag_t;
endpackage

// File: rtl/conv2_tag_dly.sv
// conv2_tag_dly: LAT-deep shift register that aligns issue tags with MAC array results.
module conv2_tag_dly
    import conv2_pkg::*;
#(
    parameter int LAT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  tag_t i_d,
    output tag_t o_q
);
    tag_t r_sr [LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) r_sr[i] <= '0;
        end else begin
            r_sr[0] <= i_d;
            for (int i = 1; i < LAT; i++) r_sr[i] <= r_sr[i-1];
        end
    end

    assign o_q = r_sr[LAT-1];
endmodule

// File: rtl/conv2_sched.sv
// conv2_sched: accepts the pooled pixel stream, stalls it per valid window and
// time-multiplexes one MAC array across OUT_CH filters, tagging every result.
module conv2_sched
    import conv2_pkg::*;
#(
    parameter int WIDTH   = 12,
    parameter int HEIGHT  = 12,
    parameter int MAC_LAT = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    output logic            o_buf_we,
    output logic            o_mac_en,
    output logic [CH_W-1:0] o_filt_sel,
    output logic [CW-1:0]   o_win_row,
    output logic [CW-1:0]   o_win_col,
    output logic            o_res_valid,
    output logic [CH_W-1:0] o_res_ch,
    output logic [CW-1:0]   o_res_row,
    output logic [CW-1:0]   o_res_col,
    output logic            o_frame_done,
    output logic            o_busy
);
    localparam logic [CW-1:0]   LAST_COL  = CW'(WIDTH - 1);
    localparam logic [CW-1:0]   LAST_ROW  = CW'(HEIGHT - 1);
    localparam logic [CW-1:0]   EDGE      = CW'(FILTER_SIZE - 1);
    localparam logic [CW-1:0]   LAST_WR   = CW'(HEIGHT - FILTER_SIZE);
    localparam logic [CW-1:0]   LAST_WC   = CW'(WIDTH - FILTER_SIZE);
    localparam logic [CH_W-1:0] LAST_CH   = CH_W'(OUT_CH - 1);
    localparam logic [7:0]      DRAIN_END = 8'(MAC_LAT - 1);

    state_t          r_state;
    logic [CW-1:0]   r_pix_row, r_pix_col, r_win_row, r_win_col;
    logic [CH_W-1:0] r_filt;
    logic [7:0]      r_drain;
    logic            r_in_ready, r_mac_en, r_last;
    logic            w_accept, w_trig, w_eol, w_eof;
    tag_t            w_tag_in, w_tag_out;

    assign w_accept = i_in_valid & r_in_ready;
    assign w_eol    = r_pix_col == LAST_COL;
    assign w_eof    = w_eol && r_pix_row == LAST_ROW;
    assign w_trig   = w_accept && r_pix_row >= EDGE && r_pix_col >= EDGE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= FILL;
            r_pix_row  <= '0;
            r_pix_col  <= '0;
            r_win_row  <= '0;
            r_win_col  <= '0;
            r_filt     <= '0;
            r_drain    <= '0;
            r_in_ready <= 1'b1;
            r_mac_en   <= 1'b0;
            r_last     <= 1'b0;
        end else begin
            case (r_state)
                FILL: if (w_accept) begin
                    r_pix_col <= w_eol ? '0 : r_pix_col + 1'b1;
                    r_pix_row <= w_eof ? '0 : (w_eol ? r_pix_row + 1'b1 : r_pix_row);
                    if (w_trig) begin
                        r_state    <= ISSUE;
                        r_in_ready <= 1'b0;
                        r_mac_en   <= 1'b1;
                        r_filt     <= '0;
                        r_win_row  <= r_pix_row - EDGE;
                        r_win_col  <= r_pix_col - EDGE;
                        r_last     <= w_eof;
                    end
                end
                ISSUE: if (r_filt == LAST_CH) begin
                    r_mac_en   <= 1'b0;
                    r_filt     <= '0;
                    r_drain    <= '0;
                    r_state    <= r_last ? DRAIN : FILL;
                    r_in_ready <= !r_last;
                end else begin
                    r_filt <= r_filt + 1'b1;
                end
                // hold the stream until the frame's final result has left the MAC array
                DRAIN: if (r_drain == DRAIN_END) begin
                    r_state    <= FILL;
                    r_in_ready <= 1'b1;
                    r_pix_row  <= '0;
                    r_pix_col  <= '0;
                end else begin
                    r_drain <= r_drain + 1'b1;
                end
                default: r_state <= FILL;
            endcase
        end
    end

    assign w_tag_in = '{valid: r_mac_en, ch: r_filt, row: r_win_row, col: r_win_col};

    conv2_tag_dly #(.LAT(MAC_LAT)) u_tag_dly (
        .clk  (clk),
        .rst_n(rst_n),
        .i_d  (w_tag_in),
        .o_q  (w_tag_out)
    );

    assign o_in_ready   = r_in_ready;
    assign o_buf_we     = w_accept;
    assign o_mac_en     = r_mac_en;
    assign o_filt_sel   = r_filt;
    assign o_win_row    = r_win_row;
    assign o_win_col    = r_win_col;
    assign o_res_valid  = w_tag_out.valid;
    assign o_res_ch     = w_tag_out.ch;
    assign o_res_row    = w_tag_out.row;
    assign o_res_col    = w_tag_out.col;
    assign o_frame_done = w_tag_out.valid && w_tag_out.ch == LAST_CH &&
                          w_tag_out.row == LAST_WR && w_tag_out.col == LAST_WC;
    assign o_busy       = r_state != FILL || r_pix_row != '0 || r_pix_col != '0;
endmodule

// File: tb/tb_conv2_sched.sv
// tb_conv2_sched: scoreboard bench; the driver predicts result tags per accepted pixel,
// the monitor pops and compares them whenever res_valid is seen.
module tb_conv2_sched;
    import conv2_pkg::*;

    logic            clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
    logic            in_ready, buf_we, mac_en, res_valid, frame_done, busy;
    logic [CH_W-1:0] filt_sel, res_ch;
    logic [CW-1:0]   win_row, win_col, res_row, res_col;

    conv2_sched dut (
        .clk(clk), .rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .o_buf_we(buf_we), .o_mac_en(mac_en), .o_filt_sel(filt_sel),
        .o_win_row(win_row), .o_win_col(win_col), .o_res_valid(res_valid),
        .o_res_ch(res_ch), .o_res_row(res_row), .o_res_col(res_col),
        .o_frame_done(frame_done), .o_busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {int ch; int row; int col;} exp_t;
    exp_t sb[$];
    int   checks = 0, failures = 0;
    int   cyc = 0;
    int   n_res = 0, n_we = 0, n_fd = 0, first_mac = -1;
    int   fd_q[$], p0_q[$];
    int   c_p52 = -1;
    int   pr = 0, pc = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_buf_we"}, buf_we, 0);
        chk({tag, "_mac_en"}, mac_en, 0);
        chk({tag, "_filt_sel"}, filt_sel, 0);
        chk({tag, "_win"}, {win_row, win_col}, 0);
        chk({tag, "_res"}, {res_valid, res_ch, res_row, res_col}, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // monitor: everything sampled at the falling edge
    initial begin
        int   prev_mac = 0, prev_f = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_mac = 0;
                prev_f   = 0;
            end else begin
                if (buf_we) n_we++;
                if (mac_en) begin
                    chk("filt_seq", filt_sel, prev_mac ? prev_f + 1 : 0);
                    chk("ready_during_issue", in_ready, 0);
                    if (first_mac < 0) begin
                        first_mac = cyc;
                        chk("first_win", {win_row, win_col}, 0);
                    end
                end
                prev_mac = mac_en;
                prev_f   = filt_sel;
                if (res_valid) begin
                    n_res++;
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL res_unexpected: got ch=%0d row=%0d col=%0d expected none",
                                 res_ch, res_row, res_col);
                    end else begin
                        e = sb.pop_front();
                        chk("res_ch", res_ch, e.ch);
                        chk("res_row", res_row, e.row);
                        chk("res_col", res_col, e.col);
                        chk("frame_done", frame_done, e.ch == OUT_CH - 1 && e.row == 7 && e.col == 7);
                    end
                end else if (frame_done) begin
                    checks++;
                    failures++;
                    $display("FAIL frame_done_no_valid: got 1 expected 0");
                end
                if (frame_done) begin
                    n_fd++;
                    fd_q.push_back(cyc);
                end
            end
        end
    end

    // entered and left just after a rising edge; gap is the idle percentage
    task automatic send_pixels(int n, int gap);
        int sent = 0;
        while (sent < n) begin
            if (gap > 0 && $urandom_range(0, 99) < gap) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end else begin
                int  w   = 0;
                bit  acc = 0;
                in_valid = 1'b1;
                while (!acc && w < 50) begin
                    @(negedge clk);
                    acc = buf_we;
                    w++;
                    if (!acc) begin
                        @(posedge clk);
                        #1;
                    end
                end
                if (!acc) begin
                    failures++;
                    $display("FAIL accept_timeout: got no accept expected accept within 50 cycles");
                    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                    $fatal(1, "accept timeout");
                end
                if (pr == 0 && pc == 0) p0_q.push_back(cyc);
                if (pr == 4 && pc == 4) c_p52 = cyc;
                if (pr >= FILTER_SIZE - 1 && pc >= FILTER_SIZE - 1)
                    for (int c = 0; c < OUT_CH; c++)
                        sb.push_back('{c, pr - FILTER_SIZE + 1, pc - FILTER_SIZE + 1});
                pc = (pc == 11) ? 0 : pc + 1;
                if (pc == 0) pr = (pr == 11) ? 0 : pr + 1;
                sent++;
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic settle();
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // two back-to-back frames, in_valid held high throughout
        send_pixels(144, 0);
        chk("first_mac_cycle", first_mac, c_p52 + 1);
        send_pixels(144, 0);
        settle();
        chk("fd_count_2f", n_fd, 2);
        if (fd_q.size() >= 1 && p0_q.size() >= 2) begin
            chk("frame_done_cycle", fd_q[0] - p0_q[0], 337);
            chk("b2b_pixel0", p0_q[1], fd_q[0] + 1);
        end
        chk("res_count_2f", n_res, 384);
        chk("we_count_2f", n_we, 288);
        chk("sb_empty_2f", sb.size(), 0);
        chk("idle_busy", busy, 0);
        chk("idle_ready", in_ready, 1);

        // random input gaps
        n_res = 0; n_we = 0; n_fd = 0;
        send_pixels(144, 50);
        settle();
        chk("res_count_gap", n_res, 192);
        chk("we_count_gap", n_we, 144);
        chk("fd_count_gap", n_fd, 1);
        chk("sb_empty_gap", sb.size(), 0);

        // reset while issuing window (3,5); pixel 93 = row 7, col 9 triggers it
        send_pixels(94, 0);
        in_valid = 1'b0;
        chk("pre_reset_mac", mac_en, 1);
        chk("pre_reset_win", {win_row, win_col}, {4'd3, 4'd5});
        chk("pre_reset_busy", busy, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        sb.delete();
        pr = 0;
        pc = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("post_reset_res", res_valid, 0);

        n_res = 0; n_we = 0; n_fd = 0; first_mac = -1;
        send_pixels(144, 20);
        chk("first_mac_after_reset", first_mac, c_p52 + 1);
        settle();
        chk("res_count_rst", n_res, 192);
        chk("fd_count_rst", n_fd, 1);
        chk("sb_empty_rst", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
